// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory bridge.
//   state_e    - bridge FSM states
//   ERR_RDATA  - load data returned to the core when a read times out
//   STRB_WIDTH - byte-strobe width for the default 32-bit data path
//   strb_width - strobe width for an arbitrary data width
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_BUSY = 2'd1,
        RD_BUSY = 2'd2,
        RD_DONE = 2'd3
    } state_e;

    localparam int unsigned ERR_RDATA          = 0;
    localparam int          DEFAULT_DATA_WIDTH = 32;
    localparam int          STRB_WIDTH         = DEFAULT_DATA_WIDTH / 8;

    function automatic int strb_width(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/dmem_store_buffer.sv
// dmem_store_buffer: one-entry posted-store buffer.
// Ports:
//   clk, rst          - clock, asynchronous active-low reset
//   capture           - load cap_* into the entry and mark it valid
//   clear             - invalidate the entry (drain done or abandoned)
//   cap_addr/data/strb- store to capture
//   sb_valid/addr/data/strb - current entry
module dmem_store_buffer #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_W     = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  capture,
    input  logic                  clear,
    input  logic [ADDR_WIDTH-1:0] cap_addr,
    input  logic [DATA_WIDTH-1:0] cap_data,
    input  logic [STRB_W-1:0]     cap_strb,
    output logic                  sb_valid,
    output logic [ADDR_WIDTH-1:0] sb_addr,
    output logic [DATA_WIDTH-1:0] sb_data,
    output logic [STRB_W-1:0]     sb_strb
);

    logic                  valid_q, valid_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [STRB_W-1:0]     strb_q, strb_d;

    // capture only happens while empty and clear only while full, so the
    // two never coincide; clear is applied last for safety anyway.
    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        data_d  = data_q;
        strb_d  = strb_q;
        if (capture) begin
            valid_d = 1'b1;
            addr_d  = cap_addr;
            data_d  = cap_data;
            strb_d  = cap_strb;
        end
        if (clear) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            strb_q  <= '0;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            strb_q  <= strb_d;
        end
    end

    assign sb_valid = valid_q;
    assign sb_addr  = addr_q;
    assign sb_data  = data_q;
    assign sb_strb  = strb_q;

endmodule

// File: rtl/dmem_bridge.sv
// dmem_bridge: converts a zero-latency core data port into a req/ack
// transfer toward a multi-cycle memory. Stores are posted through a
// one-entry buffer; loads stall the core until data returns.
// Ports:
//   clk, rst                  - clock, asynchronous active-low reset
//   cpu_addr/read/write/wdata - core request (write = byte strobes)
//   cpu_rdata, cpu_stall      - load data, core freeze
//   mem_req/we/strb/addr/wdata- registered transfer request
//   mem_ack, mem_rdata        - transfer completion and read data
//   bus_err                   - one-cycle pulse when a transfer times out
module dmem_bridge
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_WIDTH      = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   cpu_addr,
    input  logic                    cpu_read,
    input  logic [DATA_WIDTH/8-1:0] cpu_write,
    input  logic [DATA_WIDTH-1:0]   cpu_wdata,
    output logic [DATA_WIDTH-1:0]   cpu_rdata,
    output logic                    cpu_stall,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [DATA_WIDTH/8-1:0] mem_strb,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic                    mem_ack,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    output logic                    bus_err
);

    localparam int STRB_W = strb_width(DATA_WIDTH);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    state_e                state_q, state_d;
    logic                  mem_req_q, mem_req_d;
    logic                  mem_we_q, mem_we_d;
    logic [STRB_W-1:0]     mem_strb_q, mem_strb_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_WIDTH-1:0] cpu_rdata_q, cpu_rdata_d;
    logic                  bus_err_q, bus_err_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

    logic                  has_store;
    logic                  sb_capture, sb_clear;
    logic                  sb_valid;
    logic [ADDR_WIDTH-1:0] sb_addr;
    logic [DATA_WIDTH-1:0] sb_data;
    logic [STRB_W-1:0]     sb_strb;

    assign has_store  = |cpu_write;
    assign sb_capture = has_store & ~sb_valid;

    // While reset is held the core is released at once so it cannot stay
    // frozen on a transfer that reset has just dropped.
    assign cpu_stall = rst & ((cpu_read & (state_q != RD_DONE)) |
                              (has_store & sb_valid));

    dmem_store_buffer #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .STRB_W     (STRB_W)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .capture  (sb_capture),
        .clear    (sb_clear),
        .cap_addr (cpu_addr),
        .cap_data (cpu_wdata),
        .cap_strb (cpu_write),
        .sb_valid (sb_valid),
        .sb_addr  (sb_addr),
        .sb_data  (sb_data),
        .sb_strb  (sb_strb)
    );

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_strb_d  = mem_strb_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        cnt_d       = cnt_q;
        bus_err_d   = 1'b0;
        sb_clear    = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Draining first keeps a load from overtaking an older store.
                if (sb_valid) begin
                    state_d     = WR_BUSY;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_strb_d  = sb_strb;
                    mem_addr_d  = sb_addr;
                    mem_wdata_d = sb_data;
                    cnt_d       = '0;
                end else if (cpu_read) begin
                    state_d    = RD_BUSY;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_strb_d = '0;
                    mem_addr_d = cpu_addr;
                    cnt_d      = '0;
                end
            end
            WR_BUSY: begin
                // An ack in the timeout cycle still counts as success.
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    sb_clear  = 1'b1;
                    state_d   = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    mem_req_d = 1'b0;
                    bus_err_d = 1'b1;
                    sb_clear  = 1'b1;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            RD_BUSY: begin
                if (mem_ack) begin
                    mem_req_d   = 1'b0;
                    cpu_rdata_d = mem_rdata;
                    state_d     = RD_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    mem_req_d   = 1'b0;
                    bus_err_d   = 1'b1;
                    cpu_rdata_d = DATA_WIDTH'(ERR_RDATA);
                    state_d     = RD_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            RD_DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_strb_q  <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_rdata_q <= '0;
            bus_err_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_strb_q  <= mem_strb_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            bus_err_q   <= bus_err_d;
            cnt_q       <= cnt_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_strb  = mem_strb_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_rdata = cpu_rdata_q;
    assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_dmem_bridge.sv
// tb_dmem_bridge: directed and randomized checks of dmem_bridge against a
// program-order memory model, with a delay-programmable memory responder.
module tb_dmem_bridge;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int T  = 8;
    localparam int NEVER = 100000;

    logic          clk;
    logic          rst;
    logic [AW-1:0] cpu_addr;
    logic          cpu_read;
    logic [SW-1:0] cpu_write;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_stall;
    logic          mem_req;
    logic          mem_we;
    logic [SW-1:0] mem_strb;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;
    logic          bus_err;

    dmem_bridge #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_addr  (cpu_addr),
        .cpu_read  (cpu_read),
        .cpu_write (cpu_write),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_strb  (mem_strb),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .bus_err   (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [SW-1:0] strb;
        logic [DW-1:0] wdata;
    } xfer_t;

    xfer_t         log_q[$];
    logic [DW-1:0] sram    [int unsigned];   // what the memory holds
    logic [DW-1:0] ref_mem [int unsigned];   // what program order says

    function automatic logic [DW-1:0] fill(input logic [AW-1:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5AA5A5;
    endfunction

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w,
                                            input logic [DW-1:0] new_w,
                                            input logic [SW-1:0] strb);
        logic [DW-1:0] r;
        r = old_w;
        for (int b = 0; b < SW; b++)
            if (strb[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
        return r;
    endfunction

    function automatic logic [DW-1:0] sram_rd(input logic [AW-1:0] a);
        int unsigned k;
        k = a >> 2;
        return sram.exists(k) ? sram[k] : fill({a[AW-1:2], 2'b00});
    endfunction

    function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
        int unsigned k;
        k = a >> 2;
        return ref_mem.exists(k) ? ref_mem[k] : fill({a[AW-1:2], 2'b00});
    endfunction

    // ---------------- memory responder ----------------
    // Acks in req cycle number ack_delay (0 = first cycle); watches that the
    // request is held stable and dropped after ack.
    int    ack_delay = 0;
    int    cur_delay = 0;
    int    req_cnt   = 0;
    int    last_req_len = 0;
    int    hs_err    = 0;
    int    err_pulses = 0;
    xfer_t cur;

    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (rst !== 1'b1) begin
                mem_ack = 1'b0;
                req_cnt = 0;
            end else if (mem_req === 1'b1) begin
                if (req_cnt == 0) begin
                    cur = '{mem_we, mem_addr, mem_strb, mem_wdata};
                    cur_delay = ack_delay;
                    log_q.push_back(cur);
                    if (!mem_we && mem_strb != '0) hs_err++;
                end else if (cur.we !== mem_we || cur.addr !== mem_addr ||
                             cur.strb !== mem_strb || cur.wdata !== mem_wdata) begin
                    hs_err++;
                end
                if (req_cnt > cur_delay) hs_err++;
                if (req_cnt == cur_delay) begin
                    mem_ack = 1'b1;
                    if (cur.we) sram[cur.addr >> 2] = merge(sram_rd(cur.addr), cur.wdata, cur.strb);
                    else        mem_rdata = sram_rd(cur.addr);
                end else begin
                    mem_ack   = 1'b0;
                    mem_rdata = $urandom;
                end
                req_cnt++;
            end else begin
                mem_ack = 1'b0;
                if (req_cnt != 0) last_req_len = req_cnt;
                req_cnt = 0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (bus_err === 1'b1) err_pulses++;
        end
    end

    // ---------------- core-side drivers ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            cpu_read  = 1'b0;
            cpu_write = '0;
            cpu_addr  = '0;
            cpu_wdata = '0;
        end
    endtask

    task automatic do_load(input logic [AW-1:0] a, output logic [DW-1:0] d, output int stalls);
        @(negedge clk);
        cpu_addr  = a;
        cpu_read  = 1'b1;
        cpu_write = '0;
        cpu_wdata = $urandom;
        #1;
        stalls = 0;
        while (cpu_stall === 1'b1 && stalls < 300) begin
            @(negedge clk);
            #1;
            stalls++;
        end
        d = cpu_rdata;
        if (stalls >= 300) begin
            checks++; failures++;
            $display("FAIL load_wait addr=%h still stalled after %0d cycles, required release", a, stalls);
        end
    endtask

    task automatic do_store(input logic [AW-1:0] a, input logic [SW-1:0] s,
                            input logic [DW-1:0] d, input bit commit, output int stalls);
        @(negedge clk);
        cpu_addr  = a;
        cpu_read  = 1'b0;
        cpu_write = s;
        cpu_wdata = d;
        #1;
        stalls = 0;
        while (cpu_stall === 1'b1 && stalls < 300) begin
            @(negedge clk);
            #1;
            stalls++;
        end
        if (stalls >= 300) begin
            checks++; failures++;
            $display("FAIL store_wait addr=%h still stalled after %0d cycles, required release", a, stalls);
        end
        if (commit) ref_mem[a >> 2] = merge(ref_rd(a), d, s);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [1+1+SW+AW+DW+DW+1+1-1:0] outs;
        rst = 1'b0; cpu_read = 1'b0; cpu_write = '0; cpu_addr = '0; cpu_wdata = '0;
        repeat (2) @(negedge clk);
        outs = {mem_req, mem_we, mem_strb, mem_addr, mem_wdata, cpu_rdata, bus_err, cpu_stall};
        checks++;
        if (outs !== '0) begin
            failures++; $display("FAIL reset_hold outputs=%h required 0", outs);
        end
        rst = 1'b1;
        @(negedge clk); #1;
        outs = {mem_req, mem_we, mem_strb, mem_addr, mem_wdata, cpu_rdata, bus_err, cpu_stall};
        checks++;
        if (outs !== '0) begin
            failures++; $display("FAIL reset_release outputs=%h required 0", outs);
        end
        $display("test_reset done");
    endtask

    task automatic test_load_basic();
        logic [DW-1:0] d; int st;
        sram[32'h100 >> 2]    = 32'hCAFEF00D;
        ref_mem[32'h100 >> 2] = 32'hCAFEF00D;
        ack_delay = 0;
        log_q.delete();
        do_load(32'h100, d, st);
        checks++; if (st !== 2) begin failures++; $display("FAIL load_stall got=%0d required=2", st); end
        checks++; if (d !== 32'hCAFEF00D) begin failures++; $display("FAIL load_data got=%h required=cafef00d", d); end
        checks++; if (last_req_len !== 1) begin failures++; $display("FAIL load_req_len got=%0d required=1", last_req_len); end
        checks++;
        if (log_q.size() != 1 || log_q[0].we !== 1'b0 || log_q[0].addr !== 32'h100 || log_q[0].strb !== '0) begin
            failures++; $display("FAIL load_xfer count=%0d required single read of 100", log_q.size());
        end
        $display("test_load_basic addr=100 stall=%0d rdata=%h", st, d);
        idle(1);
    endtask

    task automatic test_store_isolated();
        logic [DW-1:0] d; int st; int n;
        ack_delay = 0;
        log_q.delete();
        do_store(32'h200, 4'b0011, 32'h0000_1234, 1'b1, st);
        checks++; if (st !== 0) begin failures++; $display("FAIL store_stall got=%0d required=0", st); end
        n = 0;
        do begin idle(1); #1; n++; end while (mem_req !== 1'b1 && n < 6);
        checks++;
        if (n > 2 || mem_we !== 1'b1 || mem_strb !== 4'b0011 || mem_addr !== 32'h200 || mem_wdata !== 32'h1234) begin
            failures++;
            $display("FAIL store_issue after=%0d we=%b strb=%b addr=%h wdata=%h required <=2 1 0011 200 1234",
                     n, mem_we, mem_strb, mem_addr, mem_wdata);
        end
        idle(2);
        // Buffer drained: a fresh store must be accepted without stalling.
        do_store(32'h204, 4'b1111, 32'hA5A5_0001, 1'b1, st);
        checks++; if (st !== 0) begin failures++; $display("FAIL store_after_drain stall=%0d required=0", st); end
        do_load(32'h200, d, st);
        checks++; if (d !== ref_rd(32'h200)) begin failures++; $display("FAIL store_readback got=%h required=%h", d, ref_rd(32'h200)); end
        $display("test_store_isolated addr=200 readback=%h", d);
        idle(1);
    endtask

    task automatic test_store_then_load();
        logic [DW-1:0] d; int st; logic [DW-1:0] w;
        ack_delay = 3;
        idle(2);
        log_q.delete();
        w = $urandom;
        do_store(32'h300, 4'b1111, w, 1'b1, st);
        do_load(32'h300, d, st);
        checks++; if (d !== w) begin failures++; $display("FAIL st_ld_data got=%h required=%h", d, w); end
        checks++; if (st !== 2*3 + 4) begin failures++; $display("FAIL st_ld_stall got=%0d required=%0d", st, 2*3+4); end
        checks++;
        if (log_q.size() != 2 || log_q[0].we !== 1'b1 || log_q[1].we !== 1'b0) begin
            failures++; $display("FAIL st_ld_order count=%0d required write then read", log_q.size());
        end
        $display("test_store_then_load stall=%0d rdata=%h", st, d);
        idle(1);
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] d; int st; logic [DW-1:0] wa, wb;
        ack_delay = 5;
        idle(2);
        log_q.delete();
        wa = $urandom; wb = $urandom;
        do_store(32'h340, 4'b1111, wa, 1'b1, st);
        do_store(32'h344, 4'b1100, wb, 1'b1, st);
        checks++; if (st !== 5 + 2) begin failures++; $display("FAIL b2b_stall got=%0d required=%0d", st, 5+2); end
        idle(20);
        checks++;
        if (log_q.size() != 2 || log_q[0].addr !== 32'h340 || log_q[0].wdata !== wa ||
            log_q[1].addr !== 32'h344 || log_q[1].strb !== 4'b1100 || log_q[1].wdata !== wb) begin
            failures++; $display("FAIL b2b_order count=%0d required 340 then 344", log_q.size());
        end
        ack_delay = 1;
        do_load(32'h344, d, st);
        checks++; if (d !== ref_rd(32'h344)) begin failures++; $display("FAIL b2b_data got=%h required=%h", d, ref_rd(32'h344)); end
        $display("test_back_to_back second_stall=%0d rdata=%h", 5+2, d);
        idle(1);
    endtask

    task automatic test_timeout();
        logic [DW-1:0] d; int st; int p0; int n;
        ack_delay = 0;
        do_load(32'h100, d, st);            // leaves non-zero data in cpu_rdata
        ack_delay = NEVER;
        p0 = err_pulses;
        do_load(32'h500, d, st);
        checks++; if (st !== T + 1) begin failures++; $display("FAIL rd_to_stall got=%0d required=%0d", st, T+1); end
        checks++; if (d !== '0) begin failures++; $display("FAIL rd_to_data got=%h required=0", d); end
        idle(2);
        checks++; if (last_req_len !== T) begin failures++; $display("FAIL rd_to_req_len got=%0d required=%0d", last_req_len, T); end
        checks++; if (err_pulses - p0 !== 1) begin failures++; $display("FAIL rd_to_bus_err pulses=%0d required=1", err_pulses - p0); end
        // Write timeout: the store is discarded and memory keeps the old word.
        do_store(32'h100, 4'b1111, 32'hDEADBEEF, 1'b0, st);
        n = 0;
        while (err_pulses - p0 < 2 && n < 40) begin idle(1); n++; end
        checks++; if (err_pulses - p0 !== 2) begin failures++; $display("FAIL wr_to_bus_err pulses=%0d required=2", err_pulses - p0); end
        ack_delay = 0;
        do_load(32'h100, d, st);
        checks++; if (d !== 32'hCAFEF00D) begin failures++; $display("FAIL wr_to_discard got=%h required=cafef00d", d); end
        $display("test_timeout read_stall=%0d after_write_timeout=%h", T+1, d);
        idle(1);
    endtask

    task automatic test_async_reset();
        logic [DW-1:0] d; int st;
        // Reset while a store is draining: the buffer must come back empty.
        ack_delay = NEVER;
        do_store(32'h700, 4'b1111, 32'h1111_1111, 1'b0, st);
        idle(3);
        #2 rst = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL rst_wr_req got=%b required=0", mem_req); end
        @(negedge clk); rst = 1'b1;
        ack_delay = 0;
        log_q.delete();
        idle(3);
        checks++; if (log_q.size() != 0) begin failures++; $display("FAIL rst_sb_empty xfers=%0d required=0", log_q.size()); end
        do_load(32'h700, d, st);
        checks++; if (d !== ref_rd(32'h700)) begin failures++; $display("FAIL rst_wr_data got=%h required=%h", d, ref_rd(32'h700)); end
        // Reset while a load is outstanding: request drops and core released.
        ack_delay = NEVER;
        @(negedge clk);
        cpu_read = 1'b1; cpu_addr = 32'h600; cpu_write = '0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || cpu_stall !== 1'b0) begin
            failures++; $display("FAIL rst_rd_async req=%b stall=%b required 0 0", mem_req, cpu_stall);
        end
        @(negedge clk); cpu_read = 1'b0; rst = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (mem_req !== 1'b0 || cpu_stall !== 1'b0 || bus_err !== 1'b0) begin
            failures++; $display("FAIL rst_rd_after req=%b stall=%b err=%b required 0 0 0", mem_req, cpu_stall, bus_err);
        end
        ack_delay = 0;
        $display("test_async_reset done");
        idle(1);
    endtask

    task automatic test_random();
        logic [DW-1:0] d; int st; logic [AW-1:0] a; logic [SW-1:0] s; logic [DW-1:0] w;
        int h0;
        h0 = hs_err;
        for (int i = 0; i < 150; i++) begin
            ack_delay = $urandom_range(0, 4);
            a = 32'h800 + 32'($urandom_range(0, 7)) * 4;
            if ($urandom_range(0, 9) < 6) begin
                s = SW'($urandom_range(1, 15));
                w = $urandom;
                do_store(a, s, w, 1'b1, st);
                $display("rand %0d store addr=%h strb=%b data=%h stall=%0d", i, a, s, w, st);
            end else begin
                do_load(a, d, st);
                checks++;
                if (d !== ref_rd(a)) begin
                    failures++; $display("FAIL rand_load addr=%h got=%h required=%h", a, d, ref_rd(a));
                end
                $display("rand %0d load addr=%h data=%h stall=%0d", i, a, d, st);
            end
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        idle(10);
        checks++; if (hs_err !== h0) begin failures++; $display("FAIL handshake violations=%0d required=0", hs_err - h0); end
    endtask

    initial begin
        test_reset();
        test_load_basic();
        test_store_isolated();
        test_store_then_load();
        test_back_to_back();
        test_timeout();
        test_async_reset();
        test_random();
        checks++; if (hs_err !== 0) begin failures++; $display("FAIL handshake_total violations=%0d required=0", hs_err); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dmem_bridge.md
Name: dmem_bridge

Overview:
- Sits directly downstream of the single-cycle RV32 core's data port (data_addr/data_read/data_write/data_in/data_out).
- Converts the core's zero-latency load/store interface into a req/ack handshake toward a multi-cycle data SRAM or bus.
- Stalls the core during loads and when stores collide with a pending store.
- Posts stores through a one-entry store buffer, so an isolated store costs zero stall cycles.

Parameters:
- ADDR_WIDTH, 32, byte-address width on both sides.
- DATA_WIDTH, 32, data word width; strobe width is DATA_WIDTH/8.
- TIMEOUT_CYCLES, 64, cycles of mem_req without mem_ack before the transfer is abandoned.
- CNT_WIDTH, $clog2(TIMEOUT_CYCLES+1), timeout counter width (derived).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- cpu_addr  in  ADDR_WIDTH  core data address.
- cpu_read  in  1  core load request.
- cpu_write  in  DATA_WIDTH/8  core store byte strobes; non-zero means store.
- cpu_wdata  in  DATA_WIDTH  core store data, already lane-aligned.
- cpu_rdata  out  DATA_WIDTH  load data; valid only in the cycle cpu_stall falls for a load.
- cpu_stall  out  1  freeze core PC and hold all cpu_* inputs.
- mem_req  out  1  transfer request, registered.
- mem_we  out  1  1 = write, 0 = read.
- mem_strb  out  DATA_WIDTH/8  write strobes; 0 on reads.
- mem_addr  out  ADDR_WIDTH  transfer address, passed unchanged (no alignment).
- mem_wdata  out  DATA_WIDTH  write data.
- mem_ack  in  1  transfer complete; sampled only while mem_req=1.
- mem_rdata  in  DATA_WIDTH  read data, valid with mem_ack.
- bus_err  out  1  one-cycle pulse on timeout.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; store buffer invalid; mem_req=0; mem_we=0; mem_strb=0; mem_addr=0; mem_wdata=0; cpu_rdata=0; bus_err=0; counter=0. A transfer in flight is dropped with no completion.
- Core contract: while cpu_stall=1 the core holds cpu_* stable. cpu_read=1 together with cpu_write!=0 is illegal; write takes priority.
- cpu_stall is combinational: (cpu_read & state!=RD_DONE) | (cpu_write!=0 & sb_valid).
- Store accept: cpu_write!=0 with sb_valid=0 → capture addr/wdata/strb into the buffer at the clock edge, no stall. Captured stores are not forwarded to later loads.
- States:
  - IDLE: sb_valid → WR_BUSY, assert mem_req/mem_we with the buffer contents. Else cpu_read → RD_BUSY, assert mem_req with mem_we=0, mem_strb=0, mem_addr=cpu_addr. A drain has priority over a load (preserves ordering).
  - WR_BUSY: hold all mem_* stable. mem_ack → drop mem_req, clear sb_valid, → IDLE. A store held by the core is accepted in the next cycle.
  - RD_BUSY: hold all mem_* stable. mem_ack → drop mem_req, latch mem_rdata into cpu_rdata, → RD_DONE.
  - RD_DONE: cpu_stall=0 for one cycle so the core retires the load, then → IDLE. No re-issue.
- Latency:
  - Load with empty buffer and ack in first req cycle: 2 stall cycles; rdata visible in cycle 2.
  - Load behind a pending store: adds drain time plus 1 IDLE cycle.
- Handshake: mem_req is never deasserted before ack or timeout. Address, data and strobes are stable while mem_req=1. Back-to-back transfers always have at least one cycle of mem_req=0.
- Timeout:
  - Counter clears on entry to WR_BUSY/RD_BUSY and increments each cycle without ack.
  - At count==TIMEOUT_CYCLES-1 without ack: drop mem_req, pulse bus_err.
  - Read timeout → RD_DONE with cpu_rdata=0.
  - Write timeout → discard the buffer, → IDLE.
- An ack arriving in the same cycle as the timeout wins (normal completion, no bus_err).
- Counter width is guaranteed never to wrap.

Decomposition:
- Package dmem_pkg holds:
  - state enum {IDLE, WR_BUSY, RD_BUSY, RD_DONE};
  - ERR_RDATA constant (0);
  - strobe-width localparam.
- One natural sub-module: dmem_store_buffer, one entry with valid/addr/data/strb, capture and clear inputs. All FSM, counter and handshake logic stays in dmem_bridge.

Test Plan:
- Load, ack in first req cycle, addr 0x100, mem_rdata 0xCAFEF00D → mem_req one cycle, stall 2 cycles, cpu_rdata=0xCAFEF00D with stall=0 in cycle 2.
- Isolated store, addr 0x200, strb 4'b0011, data 0x1234 → stall never asserts; next cycle mem_req=1, mem_we=1, mem_strb=0011; sb_valid clears after ack.
- Store then load next cycle, memory acks after 3 cycles → load stalls through the drain; read issued only after write ack; returned data correct.
- Two consecutive stores, first ack delayed 5 cycles → second store stalls until the buffer clears, is accepted the cycle after, then drains in order.
- Load with no ack, TIMEOUT_CYCLES=8 → mem_req drops after 8 cycles, bus_err pulses once, cpu_rdata=0, core released.
- rst low mid-RD_BUSY → mem_req=0 and stall releases immediately (asynchronously); after rst high, IDLE with an empty buffer.
